// File: rtl/hazard3_sd_bridge_mb.sv
// APB-to-SD-controller bridge: forwards a register window to the controller's Wishbone
// slave and hosts a multi-block buffer RAM shared with the controller's DMA master.
module hazard3_sd_bridge_mb #(
  parameter logic [15:0] DEVADDR  = 16'h8000,
  parameter int          NBLK     = 2,
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [15:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [7:0]  wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  input  logic [31:0] wbs_dat_i,
  output logic [3:0]  wbs_sel_o,
  output logic        wbs_we_o,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  input  logic        wbs_ack_i,
  input  logic [31:0] wbm_adr_i,
  input  logic [31:0] wbm_dat_i,
  output logic [31:0] wbm_dat_o,
  input  logic [3:0]  wbm_sel_i,
  input  logic        wbm_we_i,
  input  logic        wbm_cyc_i,
  input  logic        wbm_stb_i,
  output logic        wbm_ack_o,
  output logic        wbm_err_o
);
  localparam int WORDS = NBLK * 128;
  localparam int AW    = $clog2(WORDS);
  localparam int CW    = $clog2(TIMEOUT + 1);
  localparam logic [15:0] BUF_END = 16'(512 + NBLK * 512);
  localparam logic [31:0] DMA_END = 32'(NBLK * 512);

  typedef enum logic [2:0] {S_IDLE, S_REG, S_BUF, S_BUF_RD, S_RESP} state_t;

  typedef struct packed {
    logic          we;
    logic [7:0]    reg_adr;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic [3:0]    strb;
  } apb_req_t;

  state_t   state, state_nxt;
  apb_req_t req;
  logic     err_q;
  logic [CW-1:0] cnt;
  logic [1:0]    stat, stat_clr, stat_set;

  // ---------------- APB decode (valid only in the access cycle) ----------------
  logic          access, dec_err, is_reg, is_buf, is_loc, to_ev;
  logic [15:0]   off;
  logic [AW-1:0] buf_idx;
  logic [31:0]   loc_rdata;

  assign access  = psel & penable & (state == S_IDLE);
  assign off     = paddr - DEVADDR;
  assign buf_idx = AW'((off - 16'h0200) >> 2);
  assign dec_err = (paddr < DEVADDR) | (off >= BUF_END);
  assign is_reg  = ~dec_err & (off < 16'h0100);
  assign is_buf  = ~dec_err & (off >= 16'h0200);
  assign is_loc  = ~dec_err & ~is_reg & ~is_buf;
  assign to_ev   = (state == S_REG) && !wbs_ack_i && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    loc_rdata = '0;
    if (off == 16'h0100)      loc_rdata = {30'd0, stat};
    else if (off == 16'h0104) loc_rdata = 32'(NBLK);
  end

  // ---------------- DMA side and RAM arbitration ----------------
  logic          dma_req, dma_hit, dma_ram, dma_err_ev, apb_ram;
  logic [AW-1:0] dma_idx;

  // the cycle carrying an ack/err is dead, so a held strobe is not re-serviced
  assign dma_req    = wbm_cyc_i & wbm_stb_i & ~wbm_ack_o & ~wbm_err_o;
  assign dma_hit    = wbm_adr_i < DMA_END;
  assign dma_ram    = dma_req & dma_hit;
  assign dma_err_ev = dma_req & ~dma_hit;
  assign dma_idx    = AW'(wbm_adr_i >> 2);
  assign apb_ram    = (state == S_BUF) & ~dma_ram;

  logic            ram_en, ram_we;
  logic [AW-1:0]   ram_addr;
  logic [3:0][7:0] ram_wdata;
  logic [3:0]      ram_be;
  logic [3:0][7:0] mem [WORDS];

  always_comb begin
    ram_en    = dma_ram | apb_ram;
    ram_we    = req.we;
    ram_addr  = req.idx;
    ram_wdata = req.wdata;
    ram_be    = req.strb;
    if (dma_ram) begin
      ram_we    = wbm_we_i;
      ram_addr  = dma_idx;
      ram_wdata = wbm_dat_i;
      ram_be    = wbm_sel_i;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_en && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][b] <= ram_wdata[b];
  end

  // read port register doubles as the DMA read data output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbm_dat_o <= '0;
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
    end else begin
      if (ram_en && !ram_we) wbm_dat_o <= mem[ram_addr];
      wbm_ack_o <= dma_ram;
      wbm_err_o <= dma_err_ev;
    end
  end

  // ---------------- status: W1C, a same-cycle set wins ----------------
  assign stat_clr = (access && pwrite && is_loc && off == 16'h0100 && pstrb[0]) ? pwdata[1:0] : 2'b00;
  assign stat_set = {dma_err_ev, to_ev};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat <= '0;
    else        stat <= (stat & ~stat_clr) | stat_set;
  end

  // ---------------- APB FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (access) state_nxt = is_reg ? S_REG : (is_buf ? S_BUF : S_RESP);
      S_REG:    if (wbs_ack_i || to_ev) state_nxt = S_RESP;
      S_BUF:    if (!dma_ram) state_nxt = req.we ? S_RESP : S_BUF_RD;
      S_BUF_RD: state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pready    = 1'b0;
    pslverr   = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_we_o  = 1'b0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    case (state)
      S_REG: begin
        wbs_cyc_o = 1'b1;
        wbs_stb_o = 1'b1;
        wbs_we_o  = req.we;
        wbs_adr_o = req.reg_adr;
        wbs_dat_o = req.wdata;
        wbs_sel_o = req.we ? req.strb : 4'hf;
      end
      S_RESP: begin
        pready  = 1'b1;
        pslverr = err_q;
      end
      default: ;
    endcase
  end

  // ---------------- APB datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req    <= '0;
      err_q  <= 1'b0;
      cnt    <= '0;
      prdata <= '0;
    end else begin
      if (access) begin
        req.we      <= pwrite;
        req.reg_adr <= off[7:0];
        req.idx     <= buf_idx;
        req.wdata   <= pwdata;
        req.strb    <= pstrb;
        err_q       <= dec_err;
        cnt         <= '0;
        // local registers and decode errors answer straight away (errors read as 0)
        if (!pwrite && !is_reg && !is_buf) prdata <= loc_rdata;
      end
      if (state == S_REG) begin
        cnt <= cnt + CW'(1);
        if (wbs_ack_i) begin
          if (!req.we) prdata <= wbs_dat_i;
        end else if (to_ev) begin
          err_q <= 1'b1;
          if (!req.we) prdata <= ERR_DATA;
        end
      end
      if (state == S_BUF_RD) prdata <= wbm_dat_o;
    end
  end

endmodule

// File: tb/tb_hazard3_sd_bridge_mb.sv
// Directed bench for hazard3_sd_bridge_mb: APB buffer/register/local paths, DMA port,
// arbitration, range errors, status W1C and asynchronous reset.
`timescale 1ns/1ps
module tb_hazard3_sd_bridge_mb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [7:0]  wbs_adr_o;
  logic [31:0] wbs_dat_o, wbs_dat_i;
  logic [3:0]  wbs_sel_o;
  logic        wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_ack_i;
  logic [31:0] wbm_adr_i, wbm_dat_i, wbm_dat_o;
  logic [3:0]  wbm_sel_i;
  logic        wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_ack_o, wbm_err_o;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard3_sd_bridge_mb dut (
    .clk(clk), .rst_n(rst_n),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_dat_i(wbs_dat_i), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_ack_i(wbs_ack_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // controller model: acks in cycle T+ack_dly of a register access (0 = never)
  int          ack_dly = 0;
  int          wcnt;
  logic [7:0]  seen_adr;
  logic [31:0] seen_dat;
  logic [3:0]  seen_sel;
  logic        seen_we;
  initial begin
    wbs_ack_i = 1'b0; wbs_dat_i = '0; wcnt = 0;
    seen_adr = '0; seen_dat = '0; seen_sel = '0; seen_we = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (wbs_cyc_o && wbs_stb_o) wcnt++; else wcnt = 0;
      wbs_ack_i = (ack_dly > 0) && (wcnt == ack_dly);
      wbs_dat_i = wbs_ack_i ? (32'hC0DE0000 | 32'(wbs_adr_o)) : 32'h0;
      if (wbs_ack_i) begin
        seen_adr = wbs_adr_o; seen_dat = wbs_dat_o; seen_sel = wbs_sel_o; seen_we = wbs_we_o;
      end
    end
  end

  // called at posedge+1; lat = cycles from access cycle T to pready
  task automatic apb(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd, output logic err, output int lat);
    psel = 1'b1; penable = 1'b0; pwrite = we; paddr = addr; pwdata = wd; pstrb = st;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0; rd = '0; err = 1'b0;
    while (lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (pready) begin rd = prdata; err = pslverr; break; end
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic dma(input logic we, input logic [31:0] adr, input logic [31:0] d,
                     input logic [3:0] sel, output logic [31:0] rd, output logic ack,
                     output logic err, output int lat);
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1; wbm_we_i = we; wbm_adr_i = adr;
    wbm_dat_i = d; wbm_sel_i = sel;
    lat = 0; ack = 1'b0; err = 1'b0; rd = '0;
    while (lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (wbm_ack_o || wbm_err_o) begin ack = wbm_ack_o; err = wbm_err_o; rd = wbm_dat_o; break; end
    end
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_we_i = 1'b0;
  endtask

  logic [31:0] rd, rd2, dd;
  logic        er, er2, ak;
  int          lat, lat2;

  initial begin
    rst_n = 1'b0;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = 0; wbm_cyc_i = 0; wbm_stb_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_wbs", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o}, 32'd0);
    chk("rst_wbm", {wbm_ack_o, wbm_err_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // buffer write/read
    apb(1, 16'h8200, 32'h12345678, 4'hf, rd, er, lat);
    chk("bufw_lat", 32'(lat), 32'd2);
    chk("bufw_err", {31'd0, er}, 32'd0);
    apb(0, 16'h8200, 32'h0, 4'hf, rd, er, lat);
    chk("bufr_lat", 32'(lat), 32'd3);
    chk("bufr_data", rd, 32'h12345678);
    chk("bufr_err", {31'd0, er}, 32'd0);
    apb(1, 16'h8200, 32'hAABBCCDD, 4'b0010, rd, er, lat);
    apb(0, 16'h8200, 32'h0, 4'hf, rd, er, lat);
    chk("strb_data", rd, 32'h1234CC78);

    // controller register write, ack at T+4
    ack_dly = 4;
    apb(1, 16'h8020, 32'h55AA55AA, 4'h5, rd, er, lat);
    chk("regw_lat", 32'(lat), 32'd5);
    chk("regw_err", {31'd0, er}, 32'd0);
    chk("regw_adr", {24'd0, seen_adr}, 32'h20);
    chk("regw_dat", seen_dat, 32'h55AA55AA);
    chk("regw_sel_we", {27'd0, seen_we, seen_sel}, 32'h15);
    ack_dly = 2;
    apb(0, 16'h8044, 32'h0, 4'h3, rd, er, lat);
    chk("regr_lat", 32'(lat), 32'd3);
    chk("regr_data", rd, 32'hC0DE0044);
    chk("regr_sel_we", {27'd0, seen_we, seen_sel}, 32'h0F);

    // register timeout
    ack_dly = 0;
    apb(0, 16'h8010, 32'h0, 4'hf, rd, er, lat);
    chk("to_lat", 32'(lat), 32'd1025);
    chk("to_err", {31'd0, er}, 32'd1);
    chk("to_data", rd, 32'hDEADBEEF);
    apb(0, 16'h8100, 32'h0, 4'hf, rd, er, lat);
    chk("stat_to", rd, 32'h1);
    chk("local_lat", 32'(lat), 32'd1);
    apb(1, 16'h8100, 32'h1, 4'hf, rd, er, lat);
    chk("stat_w1c_err", {31'd0, er}, 32'd0);
    apb(0, 16'h8100, 32'h0, 4'hf, rd, er, lat);
    chk("stat_clr0", rd, 32'h0);

    // local space and range errors
    apb(0, 16'h8104, 32'h0, 4'hf, rd, er, lat);
    chk("blkcnt", rd, 32'd2);
    apb(1, 16'h8108, 32'hFFFFFFFF, 4'hf, rd, er, lat);
    chk("rsv_w_err", {31'd0, er}, 32'd0);
    apb(0, 16'h8108, 32'h0, 4'hf, rd, er, lat);
    chk("rsv_r", {rd[30:0], er}, 32'd0);
    apb(0, 16'h8600, 32'h0, 4'hf, rd, er, lat);
    chk("oor_hi", {lat[30:0], er}, {31'd1, 1'b1});
    apb(1, 16'h7FFC, 32'h1, 4'hf, rd, er, lat);
    chk("oor_lo", {lat[30:0], er}, {31'd1, 1'b1});
    apb(1, 16'h85FC, 32'hFEEDF00D, 4'hf, rd, er, lat);
    apb(0, 16'h85FC, 32'h0, 4'hf, rd, er, lat);
    chk("last_word", rd, 32'hFEEDF00D);
    chk("last_word_err", {31'd0, er}, 32'd0);

    // DMA fills block 1, APB reads it back
    dma(1, 32'h200, 32'h5A000000, 4'hf, dd, ak, er, lat);
    chk("dma_lat", 32'(lat), 32'd1);
    chk("dma_ack", {31'd0, ak}, 32'd1);
    for (int i = 1; i < 128; i++) begin
      dma(1, 32'h200 + 32'(i) * 4, 32'h5A000000 ^ (32'(i) * 32'h00010203), 4'hf, dd, ak, er, lat);
      chk($sformatf("dma_ack[%0d]", i), {31'd0, ak}, 32'd1);
    end
    for (int i = 0; i < 128; i++) begin
      apb(0, 16'h8400 + 16'(i * 4), 32'h0, 4'hf, rd, er, lat);
      chk($sformatf("blk1[%0d]", i), rd, 32'h5A000000 ^ (32'(i) * 32'h00010203));
    end
    dma(0, 32'h0, 32'h0, 4'hf, dd, ak, er, lat);
    chk("dma_rd", dd, 32'h1234CC78);
    dma(1, 32'h0, 32'h99000000, 4'b1000, dd, ak, er, lat);
    apb(0, 16'h8200, 32'h0, 4'hf, rd, er, lat);
    chk("dma_strb", rd, 32'h9934CC78);

    // DMA range error and status bit 1
    dma(1, 32'h400, 32'h1, 4'hf, dd, ak, er, lat);
    chk("dma_err", {30'd0, ak, er}, 32'h1);
    chk("dma_err_lat", 32'(lat), 32'd1);
    apb(0, 16'h8100, 32'h0, 4'hf, rd, er, lat);
    chk("stat_dma", rd, 32'h2);
    apb(1, 16'h8100, 32'h2, 4'hf, rd, er, lat);
    apb(0, 16'h8100, 32'h0, 4'hf, rd, er, lat);
    chk("stat_clr1", rd, 32'h0);

    // contention: DMA requests in the cycle APB would own the RAM
    fork
      apb(1, 16'h8204, 32'h0BADCAFE, 4'hf, rd, er, lat);
      begin
        repeat (2) begin @(posedge clk); #1; end
        dma(1, 32'h8, 32'h11112222, 4'hf, dd, ak, er2, lat2);
      end
    join
    chk("cw_apb_lat", 32'(lat), 32'd3);
    chk("cw_dma_lat", 32'(lat2), 32'd1);
    apb(0, 16'h8204, 32'h0, 4'hf, rd, er, lat);
    chk("cw_apb_data", rd, 32'h0BADCAFE);
    apb(0, 16'h8208, 32'h0, 4'hf, rd, er, lat);
    chk("cw_dma_data", rd, 32'h11112222);
    fork
      apb(0, 16'h8208, 32'h0, 4'hf, rd, er, lat);
      begin
        repeat (2) begin @(posedge clk); #1; end
        dma(1, 32'h8, 32'h33334444, 4'hf, dd, ak, er2, lat2);
      end
    join
    chk("cr_apb_lat", 32'(lat), 32'd4);
    chk("cr_dma_lat", 32'(lat2), 32'd1);
    chk("cr_apb_data", rd, 32'h33334444);

    // reset while waiting on the controller
    ack_dly = 0;
    psel = 1; penable = 0; pwrite = 1; paddr = 16'h8030; pwdata = 32'h1; pstrb = 4'hf;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    chk("rr_cyc_before", {31'd0, wbs_cyc_o}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rr_cyc_stb", {30'd0, wbs_cyc_o, wbs_stb_o}, 32'd0);
    chk("rr_pready", {31'd0, pready}, 32'd0);
    psel = 0; penable = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    apb(0, 16'h8204, 32'h0, 4'hf, rd, er, lat);
    chk("rr_keep", rd, 32'h0BADCAFE);
    apb(0, 16'h8100, 32'h0, 4'hf, rd, er, lat);
    chk("rr_stat", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
